// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster timing constants and the per-axis phase
// encoding used by the sync generator and its axis counters.
package vga_timing_pkg;

  localparam int CW = 10;  // position counter width, covers totals up to 1024
  localparam int FW = 8;   // frame counter width

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter plus an ACTIVE/FRONT/SYNC/BACK phase
// FSM that steps whenever advance is high and wraps after the back porch.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = DEF_H_DISPLAY,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  output logic [CW-1:0] count,
  output phase_e        phase,
  output phase_e        next_phase,
  output logic          wrap
);

  localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] LAST_ACTIVE = CW'(DISPLAY - 1);
  localparam logic [CW-1:0] LAST_FRONT  = CW'(DISPLAY + FRONT - 1);
  localparam logic [CW-1:0] LAST_SYNC   = CW'(DISPLAY + FRONT + SYNC - 1);
  localparam logic [CW-1:0] LAST_BACK   = CW'(TOTAL - 1);

  logic [CW-1:0] count_q, count_d;
  phase_e        phase_q, phase_d;

  // wrap is combinational: high in the cycle whose next edge returns to 0,
  // so a downstream axis can step on that very same edge.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap    = advance && (count_q == LAST_BACK);
    if (advance) begin
      count_d = wrap ? '0 : count_q + CW'(1);
      case (phase_q)
        PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (count_q == LAST_BACK)   phase_d = PH_ACTIVE;
        default:   phase_d = PH_BACK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= LAST_BACK;
      phase_q <= PH_BACK;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count      = count_q;
  assign phase      = phase_q;
  assign next_phase = phase_d;

endmodule

// File: rtl/vga_hvsync_gen.sv
// VGA raster timing generator: beam position, sync pulses, blanking flag,
// line/frame strobes and a completed-frame counter, all registered together.
module vga_hvsync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          display_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count,
  output phase_e        dbg_h_phase,
  output phase_e        dbg_v_phase
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam logic [CW-1:0] LAST_V_ACTIVE = CW'(V_DISPLAY - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_hvsync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  phase_e h_next, v_next;
  logic   h_wrap, v_wrap;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (1'b1),
    .count      (pix_x),
    .phase      (dbg_h_phase),
    .next_phase (h_next),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .advance    (h_wrap),
    .count      (pix_y),
    .phase      (dbg_v_phase),
    .next_phase (v_next),
    .wrap       (v_wrap)
  );

  logic          display_on_q, display_on_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [FW-1:0] frame_count_q, frame_count_d;

  // Decoded from next-state phases so these flops land on the same edge as
  // the position counters they describe.
  always_comb begin
    display_on_d  = (h_next == PH_ACTIVE) && (v_next == PH_ACTIVE);
    hsync_d       = (h_next == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = (v_next == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    frame_count_d = frame_count_q;
    if (h_wrap && (pix_y == LAST_V_ACTIVE)) frame_count_d = frame_count_q + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      display_on_q  <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign display_on  = display_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Bench for vga_hvsync_gen: three timing variants share clock and reset and
// are compared every cycle against a position model derived from elapsed time.
module tb_vga_hvsync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int t = -1;  // cycles since reset release; -1 means the reset state

  // Default 640x480 timing
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic [1:0] a_hp, a_vp;
  logic a_disp, a_hs, a_vs, a_ls, a_fs;
  vga_hvsync_gen u_dut_a (
    .clk(clk), .reset(reset), .pix_x(a_x), .pix_y(a_y), .display_on(a_disp),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs),
    .frame_count(a_fc), .dbg_h_phase(a_hp), .dbg_v_phase(a_vp)
  );

  // Tiny raster so full frames and the frame counter wrap fit in the run
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;
  logic [1:0] b_hp, b_vp;
  logic b_disp, b_hs, b_vs, b_ls, b_fs;
  vga_hvsync_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .pix_x(b_x), .pix_y(b_y), .display_on(b_disp),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc), .dbg_h_phase(b_hp), .dbg_v_phase(b_vp)
  );

  // Half-width horizontal timing, default vertical
  logic [9:0] c_x, c_y;
  logic [7:0] c_fc;
  logic [1:0] c_hp, c_vp;
  logic c_disp, c_hs, c_vs, c_ls, c_fs;
  vga_hvsync_gen #(
    .H_DISPLAY(320), .H_FRONT(8), .H_SYNC(48), .H_BACK(24)
  ) u_dut_c (
    .clk(clk), .reset(reset), .pix_x(c_x), .pix_y(c_y), .display_on(c_disp),
    .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs),
    .frame_count(c_fc), .dbg_h_phase(c_hp), .dbg_v_phase(c_vp)
  );

  function automatic int phase_of(input int p, input int d, input int f, input int s);
    if (p < d) return 0;
    if (p < d + f) return 1;
    if (p < d + f + s) return 2;
    return 3;
  endfunction

  // Expected outputs after t cycles of free running from reset release:
  // {x, y, frame_count, h_phase, v_phase, display_on, hsync, vsync, line_start, frame_start}
  function automatic logic [39:0] model(input int tt,
                                        input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb);
    int ht, vt, x, y, fc, hp, vp;
    logic disp, hsy, vsy, ls, fs;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    if (tt < 0)
      return {10'(ht - 1), 10'(vt - 1), 8'd0, 2'd3, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    x   = tt % ht;
    y   = (tt / ht) % vt;
    fc  = (tt >= vd * ht) ? ((tt - vd * ht) / (ht * vt) + 1) : 0;
    hp  = phase_of(x, hd, hf, hs);
    vp  = phase_of(y, vd, vf, vs);
    disp = (x < hd) && (y < vd);
    hsy = !((x >= hd + hf) && (x < hd + hf + hs));
    vsy = !((y >= vd + vf) && (y < vd + vf + vs));
    ls  = (x == 0);
    fs  = (x == 0) && (y == 0);
    return {10'(x), 10'(y), 8'(fc), 2'(hp), 2'(vp), disp, hsy, vsy, ls, fs};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    check("dflt", {a_x, a_y, a_fc, a_hp, a_vp, a_disp, a_hs, a_vs, a_ls, a_fs},
          model(t, 640, 16, 96, 48, 480, 10, 2, 33));
    check("tiny", {b_x, b_y, b_fc, b_hp, b_vp, b_disp, b_hs, b_vs, b_ls, b_fs},
          model(t, 8, 1, 2, 1, 6, 1, 1, 1));
    check("h320", {c_x, c_y, c_fc, c_hp, c_vp, c_disp, c_hs, c_vs, c_ls, c_fs},
          model(t, 320, 8, 48, 24, 480, 10, 2, 33));
  endtask

  // Apply reset level r across one clock edge, then check away from the edge.
  task automatic cycle(input logic r);
    reset = r;
    @(posedge clk);
    t = r ? -1 : t + 1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;

    // Step 1: reset held for three edges
    repeat (3) cycle(1'b1);

    // Step 2: free run across at least one full default line
    n = $urandom_range(820, 1500);
    repeat (n) cycle(1'b0);

    // Step 3: single-cycle reset mid-line, then restart at (0,0)
    cycle(1'b1);
    cycle(1'b0);

    // Step 4: long run; the tiny raster passes 256+ frames and wraps frame_count
    n = 256 * 108 + 6 * 12 + $urandom_range(0, 300);
    repeat (n) cycle(1'b0);

    // Step 5: random-length reset at an arbitrary point, then recover
    n = $urandom_range(1, 3);
    repeat (n) cycle(1'b1);
    n = $urandom_range(300, 700);
    repeat (n) cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
